display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, clock cycles per digit slot (>= GUARD+2).
REQ-002 SHALL have parameter GUARD, default 16, dead cycles at slot start with all anodes off (>= 1).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable_i, input, 1, display on when high.
REQ-006 SHALL have port load_i, input, 1, one-cycle strobe capturing data_i.
REQ-007 SHALL have port data_i, input, 16, four nibbles; [3:0] is digit 0 (rightmost).
REQ-008 SHALL have port nibble_o, output, 4, selected digit value, driving the seven-segment decoder.
REQ-009 SHALL have port an_o, output, 4, digit anodes, active-low.
REQ-010 SHALL have port digit_idx_o, output, 2, current digit slot.
REQ-011 SHALL have port frame_tick_o, output, 1, one-cycle pulse at digit 3 -> 0 wrap.
REQ-012 SHALL have port pending_o, output, 1, high while a captured value awaits frame boundary.

Function
REQ-013 SHALL implement FSM states OFF, DEAD, ON.
REQ-014 OFF: an_o=4'b1111, slot counter cnt=0, idx=0; enable_i high -> DEAD next cycle.
REQ-015 DEAD: an_o=4'b1111 for cnt 0..GUARD-1; at cnt=GUARD-1 -> ON.
REQ-016 ON: an_o bit idx low, others high, for cnt GUARD..PRESCALE-1; at cnt=PRESCALE-1: cnt=0, idx=idx+1 mod 4, -> DEAD.
REQ-017 enable_i low in DEAD or ON SHALL force OFF next cycle, abandoning the slot.
REQ-018 nibble_o SHALL equal disp_reg[4*idx+3:4*idx] combinationally from registered idx.
REQ-019 load_i in OFF SHALL write data_i into disp_reg next cycle; pending_o stays 0.
REQ-020 load_i in DEAD/ON SHALL write data_i into shadow_reg, set pending_o; disp_reg unchanged (no tearing).
REQ-021 Repeated load_i while pending SHALL overwrite shadow_reg; last value wins.
REQ-022 At the 3->0 wrap cycle SHALL pulse frame_tick_o, copy shadow_reg to disp_reg if pending, clear pending_o.
REQ-023 load_i coincident with wrap SHALL capture into shadow_reg and leave pending_o set; previous shadow still applied.
REQ-024 Leaving DEAD/ON for OFF with pending set SHALL apply shadow_reg to disp_reg and clear pending_o.

Reset
REQ-025 rst high SHALL asynchronously force OFF, cnt=0, idx=0, disp_reg=0, shadow_reg=0, pending_o=0, frame_tick_o=0, an_o=4'b1111, nibble_o=0.
REQ-026 Reset mid-slot SHALL abandon the slot; first lit digit after release is digit 0 following a full GUARD.

Configuration
REQ-027 Macro DISPLAY_SCAN_LEADING_ZERO_BLANK_EN defined: in ON, digit k (k=1..3) SHALL keep an_o high when nibble k and all higher nibbles of disp_reg are zero; digit 0 always lit.
REQ-028 Macro undefined: all four digits SHALL light in ON regardless of value; timing identical in both builds.

Structure
REQ-029 Package disp_pkg SHALL hold the state enum (OFF, DEAD, ON), NUM_DIGITS=4, ANODES_OFF=4'b1111.
REQ-030 Sub-module scan_prescaler (cnt, slot-end and guard-end flags) SHALL be instantiated; FSM, registers and mux stay in top.

Verification (PRESCALE=8, GUARD=2)
REQ-031 Reset, enable_i=1 -> an_o 1111 for 2 cycles, 1110 for 6, then 1111 x2, 1101 x6; frame_tick_o once per 32 cycles.
REQ-032 In OFF load 16'h12AF -> nibble_o 4'hF at idx0, 4'hA at idx1, 4'h2 idx2, 4'h1 idx3.
REQ-033 Scanning, load 16'h1111 then 16'h2222 mid-frame -> pending_o=1, display unchanged until wrap, then 16'h2222.
REQ-034 enable_i dropped during ON of idx2 -> an_o 1111 next cycle; re-enable starts DEAD at idx0.
REQ-035 With DISPLAY_SCAN_LEADING_ZERO_BLANK_EN, disp_reg 16'h0050 -> idx3, idx2 anodes stay high; idx1 and idx0 lit.
REQ-036 rst asserted mid-ON with pending_o=1 -> all outputs to reset values without waiting for clk edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the four-digit display scan controller.
// Holds the scan FSM state enum, digit count, idle anode pattern and anode decode.
package disp_pkg;

   localparam int NUM_DIGITS = 4;
   localparam logic [3:0] ANODES_OFF = 4'b1111;

   typedef enum logic [1:0] {
      OFF,
      DEAD,
      ON
   } state_t;

   // Active-low one-cold anode pattern for a digit slot
   function automatic logic [3:0] anode_sel(input logic [1:0] idx);
      anode_sel = ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timing counter for the display scan controller.
// Ports: clk, rst (async high), clr (hold count at 0),
//        slot_end (count at PRESCALE-1), guard_end (count at GUARD-1).
module scan_prescaler #(
   parameter int PRESCALE = 50000,
   parameter int GUARD    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic slot_end,
   output logic guard_end
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CW-1:0] cnt;

   assign slot_end  = (cnt == CW'(PRESCALE - 1));
   assign guard_end = (cnt == CW'(GUARD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (slot_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed four-digit seven-segment scan controller with guard gaps
// and frame-synchronous (tear-free) display updates.
// Ports: clk, rst (async high), enable_i, load_i, data_i[15:0],
//        nibble_o[3:0], an_o[3:0] (active low), digit_idx_o[1:0],
//        frame_tick_o, pending_o.
// Option: DISPLAY_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_scan_controller
   import disp_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int GUARD    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_i,
   input  logic        load_i,
   input  logic [15:0] data_i,
   output logic [3:0]  nibble_o,
   output logic [3:0]  an_o,
   output logic [1:0]  digit_idx_o,
   output logic        frame_tick_o,
   output logic        pending_o
);

   state_t      state;
   logic [1:0]  idx;
   logic [15:0] disp_reg;
   logic [15:0] shadow_reg;
   logic        pending;
   logic        frame_tick;
   logic [3:0]  an;

   logic slot_end;
   logic guard_end;
   logic clr;
   logic leave;
   logic wrap;
   logic lit;

   assign clr   = (state == OFF) || !enable_i;
   assign leave = (state != OFF) && !enable_i;
   assign wrap  = (state == ON) && enable_i && slot_end && (idx == 2'd3);

   scan_prescaler #(
      .PRESCALE (PRESCALE),
      .GUARD    (GUARD)
   ) u_prescaler (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .slot_end  (slot_end),
      .guard_end (guard_end)
   );

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
   // A digit is lit when it or any more significant nibble is non-zero
   always_comb begin
      lit = 1'b1;
      unique case (idx)
         2'd0: lit = 1'b1;
         2'd1: lit = |disp_reg[15:4];
         2'd2: lit = |disp_reg[15:8];
         2'd3: lit = |disp_reg[15:12];
         default: lit = 1'b1;
      endcase
   end
`else
   assign lit = 1'b1;
`endif

   // Scan FSM; the anode pattern is registered together with the state.
   // disp_reg only changes on edges where the anodes go dark, so the
   // blanking decision taken on DEAD->ON holds for the whole lit phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= OFF;
         idx   <= 2'd0;
         an    <= ANODES_OFF;
      end else begin
         unique case (state)
            OFF: begin
               idx <= 2'd0;
               an  <= ANODES_OFF;
               if (enable_i) begin
                  state <= DEAD;
               end
            end
            DEAD: begin
               if (!enable_i) begin
                  state <= OFF;
                  idx   <= 2'd0;
                  an    <= ANODES_OFF;
               end else if (guard_end) begin
                  state <= ON;
                  an    <= lit ? anode_sel(idx) : ANODES_OFF;
               end
            end
            ON: begin
               if (!enable_i) begin
                  state <= OFF;
                  idx   <= 2'd0;
                  an    <= ANODES_OFF;
               end else if (slot_end) begin
                  state <= DEAD;
                  idx   <= idx + 2'd1;
                  an    <= ANODES_OFF;
               end
            end
            default: begin
               state <= OFF;
               idx   <= 2'd0;
               an    <= ANODES_OFF;
            end
         endcase
      end
   end

   // Display and shadow registers. While scanning, new values wait in
   // shadow_reg until the frame wraps or the display is switched off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_reg   <= 16'h0000;
         shadow_reg <= 16'h0000;
         pending    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= wrap;
         if (state == OFF) begin
            if (load_i) begin
               disp_reg <= data_i;
            end
         end else if (leave) begin
            // Display goes dark this edge, so a fresh value can land directly
            if (load_i) begin
               disp_reg   <= data_i;
               shadow_reg <= data_i;
            end else if (pending) begin
               disp_reg <= shadow_reg;
            end
            pending <= 1'b0;
         end else begin
            if (wrap && pending) begin
               disp_reg <= shadow_reg;
            end
            if (load_i) begin
               shadow_reg <= data_i;
               pending    <= 1'b1;
            end else if (wrap) begin
               pending <= 1'b0;
            end
         end
      end
   end

   assign nibble_o     = disp_reg[4*idx +: 4];
   assign an_o         = an;
   assign digit_idx_o  = idx;
   assign frame_tick_o = frame_tick;
   assign pending_o    = pending;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed self-checking bench for display_scan_controller
// (PRESCALE=8, GUARD=2): scan timing, loads, frame sync, enable, reset.
module tb_display_scan_controller;

   logic        clk;
   logic        rst;
   logic        enable_i;
   logic        load_i;
   logic [15:0] data_i;
   logic [3:0]  nibble_o;
   logic [3:0]  an_o;
   logic [1:0]  digit_idx_o;
   logic        frame_tick_o;
   logic        pending_o;

   int total = 0;
   int bad   = 0;

   display_scan_controller #(
      .PRESCALE (8),
      .GUARD    (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .load_i       (load_i),
      .data_i       (data_i),
      .nibble_o     (nibble_o),
      .an_o         (an_o),
      .digit_idx_o  (digit_idx_o),
      .frame_tick_o (frame_tick_o),
      .pending_o    (pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] an;
      logic [1:0] idx;
      logic [3:0] nib;
      logic       tick;
   } vec_t;

   vec_t vt[40];

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] nib_of(input logic [15:0] v,
                                         input int i);
      logic [15:0] t;
      t = v >> (4 * i);
      return t[3:0];
   endfunction

   logic [15:0] val;
   logic [3:0]  lit_seen;
   logic [3:0]  lit_exp;
   int          c;
   bit          found;

   initial begin
      // Expected scan pattern for the first 40 cycles after enable
      val = 16'h12AF;
      for (int k = 0; k < 40; k++) begin
         vt[k].idx  = 2'((k / 8) % 4);
         vt[k].an   = ((k % 8) < 2) ? 4'b1111 : ~(4'b0001 << vt[k].idx);
         vt[k].nib  = nib_of(val, (k / 8) % 4);
         vt[k].tick = (k == 32);
      end

      rst      = 1'b1;
      enable_i = 1'b0;
      load_i   = 1'b0;
      data_i   = 16'h0000;
      #12;
      chk("rst_an", 16'(an_o), 16'hF);
      chk("rst_nib", 16'(nibble_o), 16'h0);
      chk("rst_idx", 16'(digit_idx_o), 16'h0);
      chk("rst_pend", 16'(pending_o), 16'h0);
      chk("rst_tick", 16'(frame_tick_o), 16'h0);
      rst = 1'b0;

      // Load while off goes straight to the display
      step();
      load_i = 1'b1;
      data_i = 16'h12AF;
      step();
      load_i = 1'b0;
      chk("off_load_pend", 16'(pending_o), 16'h0);
      chk("off_load_nib", 16'(nibble_o), 16'hF);
      chk("off_an", 16'(an_o), 16'hF);

      enable_i = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         chk($sformatf("scan_an[%0d]", k), 16'(an_o), 16'(vt[k].an));
         chk($sformatf("scan_idx[%0d]", k), 16'(digit_idx_o),
             16'(vt[k].idx));
         chk($sformatf("scan_nib[%0d]", k), 16'(nibble_o), 16'(vt[k].nib));
         chk($sformatf("scan_tick[%0d]", k), 16'(frame_tick_o),
             16'(vt[k].tick));
      end
      c = 39;

      // Two loads mid-frame: held back until the wrap, last one wins
      load_i = 1'b1;
      data_i = 16'h1111;
      step(); c++;
      load_i = 1'b0;
      chk("pend_set", 16'(pending_o), 16'h1);
      chk("pend_hold_nib", 16'(nibble_o), 16'hA);
      step(); c++;
      load_i = 1'b1;
      data_i = 16'h2222;
      step(); c++;
      load_i = 1'b0;
      chk("pend_set2", 16'(pending_o), 16'h1);
      while (c < 63) begin
         step(); c++;
         chk($sformatf("tear_nib[%0d]", c), 16'(nibble_o),
             16'(nib_of(val, (c / 8) % 4)));
         chk($sformatf("tear_tick[%0d]", c), 16'(frame_tick_o), 16'h0);
      end
      step(); c++;
      chk("wrap_tick", 16'(frame_tick_o), 16'h1);
      chk("wrap_nib", 16'(nibble_o), 16'h2);
      chk("wrap_pend", 16'(pending_o), 16'h0);
      chk("wrap_idx", 16'(digit_idx_o), 16'h0);

      // Load exactly on the wrap edge: old shadow applied, new one pending
      while (c < 68) begin
         step(); c++;
      end
      load_i = 1'b1;
      data_i = 16'h3333;
      step(); c++;
      load_i = 1'b0;
      chk("pend3", 16'(pending_o), 16'h1);
      chk("pend3_nib", 16'(nibble_o), 16'h2);
      while (c < 95) begin
         step(); c++;
      end
      load_i = 1'b1;
      data_i = 16'h4444;
      step(); c++;
      load_i = 1'b0;
      chk("coin_tick", 16'(frame_tick_o), 16'h1);
      chk("coin_nib", 16'(nibble_o), 16'h3);
      chk("coin_pend", 16'(pending_o), 16'h1);
      while (c < 128) begin
         step(); c++;
      end
      chk("coin2_tick", 16'(frame_tick_o), 16'h1);
      chk("coin2_nib", 16'(nibble_o), 16'h4);
      chk("coin2_pend", 16'(pending_o), 16'h0);

      // Disable during digit 2 with a pending value
      load_i = 1'b1;
      data_i = 16'h5555;
      step(); c++;
      load_i = 1'b0;
      chk("pend5", 16'(pending_o), 16'h1);
      while (c < 146) begin
         step(); c++;
      end
      chk("idx2_an", 16'(an_o), 16'b1011);
      chk("idx2_idx", 16'(digit_idx_o), 16'h2);
      enable_i = 1'b0;
      step();
      chk("dis_an", 16'(an_o), 16'hF);
      chk("dis_idx", 16'(digit_idx_o), 16'h0);
      chk("dis_pend", 16'(pending_o), 16'h0);
      chk("dis_nib", 16'(nibble_o), 16'h5);
      step();
      chk("off_hold_an", 16'(an_o), 16'hF);
      enable_i = 1'b1;
      step();
      chk("reen_dead0", 16'(an_o), 16'hF);
      chk("reen_idx", 16'(digit_idx_o), 16'h0);
      step();
      chk("reen_dead1", 16'(an_o), 16'hF);
      step();
      chk("reen_on", 16'(an_o), 16'b1110);

      // Leading-zero blanking on a small value
      enable_i = 1'b0;
      step();
      load_i = 1'b1;
      data_i = 16'h0050;
      step();
      load_i   = 1'b0;
      enable_i = 1'b1;
      chk("lz_nib0", 16'(nibble_o), 16'h0);
      lit_seen = 4'b0000;
      for (int k = 0; k < 40; k++) begin
         step();
         lit_seen = lit_seen | ~an_o;
      end
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
      lit_exp = 4'b0011;
`else
      lit_exp = 4'b1111;
`endif
      chk("lz_lit", 16'(lit_seen), 16'(lit_exp));

      // Asynchronous reset mid-ON with a pending value
      load_i = 1'b1;
      data_i = 16'h6666;
      step();
      load_i = 1'b0;
      chk("rst_pre_pend", 16'(pending_o), 16'h1);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (an_o != 4'hF) found = 1'b1;
      end
      chk("lit_wait", 16'(found), 16'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_an", 16'(an_o), 16'hF);
      chk("arst_nib", 16'(nibble_o), 16'h0);
      chk("arst_idx", 16'(digit_idx_o), 16'h0);
      chk("arst_pend", 16'(pending_o), 16'h0);
      chk("arst_tick", 16'(frame_tick_o), 16'h0);
      #1;
      rst = 1'b0;
      step();
      chk("post_rst_dead0", 16'(an_o), 16'hF);
      step();
      chk("post_rst_dead1", 16'(an_o), 16'hF);
      step();
      chk("post_rst_on", 16'(an_o), 16'b1110);
      chk("post_rst_idx", 16'(digit_idx_o), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
